// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: active-low glyph table (seg[6:0] = a..g),
// the capture FSM state type, and a nibble-to-glyph helper for the driver side.
package ssd_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_HELD  = 2'd1,
    S_BLANK = 2'd2
  } ssd_cap_state_t;

  // Nibble to active-low glyph, used by the driver end of the loopback.
  function automatic logic [6:0] ssd_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      4'hF: g = GLYPH_F;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational inverse of the glyph table: active-low seg[6:0] -> {valid, nibble}.
// Any pattern outside the sixteen hex glyphs reports valid=0, nibble=0.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  // Glyph lookup; unknown patterns fall through to the invalid default.
  always_comb begin
    valid_o  = 1'b1;
    nibble_o = 4'h0;
    case (seg_i)
      GLYPH_0: nibble_o = 4'h0;
      GLYPH_1: nibble_o = 4'h1;
      GLYPH_2: nibble_o = 4'h2;
      GLYPH_3: nibble_o = 4'h3;
      GLYPH_4: nibble_o = 4'h4;
      GLYPH_5: nibble_o = 4'h5;
      GLYPH_6: nibble_o = 4'h6;
      GLYPH_7: nibble_o = 4'h7;
      GLYPH_8: nibble_o = 4'h8;
      GLYPH_9: nibble_o = 4'h9;
      GLYPH_A: nibble_o = 4'hA;
      GLYPH_B: nibble_o = 4'hB;
      GLYPH_C: nibble_o = 4'hC;
      GLYPH_D: nibble_o = 4'hD;
      GLYPH_E: nibble_o = 4'hE;
      GLYPH_F: nibble_o = 4'hF;
      default: begin
        valid_o  = 1'b0;
        nibble_o = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/ssd_capture.sv
// ssd_capture: samples a multiplexed 4-digit active-low SSD bus, commits each digit
// once per stable dwell, and publishes the reassembled 16-bit value with data_valid.
// Optional macro SSD_CAPTURE_DP_EN adds dp_out carrying the per-digit decimal points.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2**20
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  anode,
  input  logic [7:0]  seg,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        pattern_err,
  output logic        frame_err
`ifdef SSD_CAPTURE_DP_EN
  ,
  output logic [3:0]  dp_out
`endif
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  logic [11:0]    sync1_q, sync2_q, prev_q;
  logic [SW-1:0]  stab_q, stab_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  ssd_cap_state_t state_q, state_d;
  logic [15:0]    slots_q, slots_d;
  logic [3:0]     seen_q, seen_d;
  logic [15:0]    dout_q, dout_d;
  logic           dvalid_q, dvalid_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
`ifdef SSD_CAPTURE_DP_EN
  logic [3:0]     dp_slots_q, dp_slots_d;
  logic [3:0]     dp_out_q, dp_out_d;
`endif

  logic [3:0] smp_anode_s;
  logic [7:0] smp_seg_s;
  logic       change_s, blank_s, commit_s;
  logic       glyph_ok_s, onehot_s;
  logic [3:0] nibble_s;
  logic [1:0] idx_s;

  assign smp_anode_s = sync2_q[11:8];
  assign smp_seg_s   = sync2_q[7:0];
  assign change_s    = (sync2_q != prev_q);
  assign blank_s     = (smp_anode_s == 4'hF);
  // Commit exactly once when the sample has been unchanged for STABLE_CYCLES samples.
  assign commit_s    = (state_q == S_WAIT) && !blank_s && !change_s && (stab_q == STAB_MAX);

  ssd_seg_decode u_dec (
    .seg_i    (smp_seg_s[6:0]),
    .valid_o  (glyph_ok_s),
    .nibble_o (nibble_s)
  );

  // Two-flop synchronizer plus the previous-sample register used for change detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 12'hFFF;
      sync2_q <= 12'hFFF;
      prev_q  <= 12'hFFF;
    end else begin
      sync1_q <= {anode, seg};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Anode one-hot-low decode to a digit index; anything else is a bus error.
  always_comb begin
    onehot_s = 1'b1;
    idx_s    = 2'd0;
    case (smp_anode_s)
      4'b1110: idx_s = 2'd0;
      4'b1101: idx_s = 2'd1;
      4'b1011: idx_s = 2'd2;
      4'b0111: idx_s = 2'd3;
      default: onehot_s = 1'b0;
    endcase
  end

  // Capture FSM next state: blank bus overrides everything.
  always_comb begin
    state_d = state_q;
    if (blank_s) begin
      state_d = S_BLANK;
    end else begin
      case (state_q)
        S_WAIT:  state_d = commit_s ? S_HELD : S_WAIT;
        S_HELD:  state_d = change_s ? S_WAIT : S_HELD;
        S_BLANK: state_d = S_WAIT;
        default: state_d = S_WAIT;
      endcase
    end
  end

  // Stability counter, timeout, slot/seen bookkeeping and output pulses.
  always_comb begin
    stab_d   = change_s ? {SW{1'b0}} : ((stab_q == STAB_MAX) ? STAB_MAX : stab_q + SW'(1));
    tmo_d    = (tmo_q == TMO_MAX) ? {TW{1'b0}} : tmo_q + TW'(1);
    slots_d  = slots_q;
    seen_d   = seen_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = ferr_q;
`ifdef SSD_CAPTURE_DP_EN
    dp_slots_d = dp_slots_q;
    dp_out_d   = dp_out_q;
`endif
    if (commit_s) begin
      tmo_d = {TW{1'b0}};
      if (onehot_s && glyph_ok_s) begin
        slots_d[{idx_s, 2'b00} +: 4] = nibble_s;
        seen_d[idx_s]                = 1'b1;
`ifdef SSD_CAPTURE_DP_EN
        dp_slots_d[idx_s] = ~smp_seg_s[7];
`endif
        // The completing digit is folded in so data_out lands on the next edge.
        if (seen_d == 4'hF) begin
          dout_d   = slots_d;
          dvalid_d = 1'b1;
          seen_d   = 4'h0;
          ferr_d   = 1'b0;
`ifdef SSD_CAPTURE_DP_EN
          dp_out_d = dp_slots_d;
`endif
        end else begin
          ferr_d = ferr_q;
        end
      end else if (onehot_s) begin
        perr_d = 1'b1;
        ferr_d = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
    end else if (tmo_q == TMO_MAX) begin
      seen_d = 4'h0;
      ferr_d = 1'b0;
    end else begin
      seen_d = seen_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WAIT;
      stab_q   <= {SW{1'b0}};
      tmo_q    <= {TW{1'b0}};
      slots_q  <= 16'h0000;
      seen_q   <= 4'h0;
      dout_q   <= 16'h0000;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef SSD_CAPTURE_DP_EN
      dp_slots_q <= 4'h0;
      dp_out_q   <= 4'h0;
`endif
    end else begin
      state_q  <= state_d;
      stab_q   <= stab_d;
      tmo_q    <= tmo_d;
      slots_q  <= slots_d;
      seen_q   <= seen_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
`ifdef SSD_CAPTURE_DP_EN
      dp_slots_q <= dp_slots_d;
      dp_out_q   <= dp_out_d;
`endif
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = dvalid_q;
  assign pattern_err = perr_q;
  assign frame_err   = ferr_q;
`ifdef SSD_CAPTURE_DP_EN
  assign dp_out      = dp_out_q;
`endif

endmodule
